// File: rtl/frame_pkg.sv
// Shared types and line-level constants for the frame serializer.
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter: flags the last cycle of a bit and the mid-bit strobe cycle.
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic c,
  input  logic rst_n,
  input  logic i_en,
  output logic o_bit_end,
  output logic o_mid
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  // Held at zero while disabled so every frame starts on a fresh bit boundary.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || o_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_end = i_en && (r_cnt == CW'(DIV - 1));
  assign o_mid     = i_en && (r_cnt == CW'(DIV / 2));

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial framer (start, LSB-first data, optional parity, stop) with a
// mid-bit gate strobe for a downstream D-latch.
module frame_serializer
  import frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DIV        = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  output logic              sd,
  output logic              sc,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic [IW-1:0]     r_bit_idx;
  logic              r_done;
  logic              w_sd;
  logic              w_busy;
  logic              w_accept;
  logic              w_bit_end;
  logic              w_mid;

  assign w_busy   = (r_state != IDLE);
  assign w_accept = load && !w_busy;

  bit_timer #(
    .DIV(DIV)
  ) u_bit_timer (
    .c        (c),
    .rst_n    (rst_n),
    .i_en     (w_busy),
    .o_bit_end(w_bit_end),
    .o_mid    (w_mid)
  );

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sd         = LINE_IDLE;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = START;
      end
      START: begin
        w_sd = START_BIT;
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        w_sd = r_shift[0];
        if (w_bit_end && (r_bit_idx == LAST_IDX)) begin
          w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        w_sd = r_parity;
        if (w_bit_end) w_state_next = STOP;
      end
      STOP: begin
        if (w_bit_end) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Parity is fixed at capture time; the shift register is consumed during DATA.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_idx <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == STOP) && w_bit_end;
      if (w_accept) begin
        r_shift   <= din;
        r_parity  <= (^din) ^ (PARITY_ODD != 0);
        r_bit_idx <= '0;
      end else if ((r_state == DATA) && w_bit_end) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= (r_bit_idx == LAST_IDX) ? '0 : r_bit_idx + 1'b1;
      end
    end
  end

  assign sd    = w_sd;
  assign sc    = w_mid;
  assign busy  = w_busy;
  assign ready = !w_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_frame_serializer.sv
// Self-checking bench: four parameterisations checked cycle-by-cycle against a frame model.
module tb_frame_serializer;

  logic       clk;
  logic       rst_n;
  logic [3:0] ld;
  logic [7:0] din8 [3];
  logic       din3;
  logic [3:0] sd_w, sc_w, busy_w, done_w, rdy_w;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int inst;
    int word;
    int dw;
    int div;
    int pen;
    int podd;
    int exp_len;
    int exp_cap;
  } vec_t;

  vec_t vecs [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  frame_serializer #(.DATA_W(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
    .c(clk), .rst_n(rst_n), .din(din8[0]), .load(ld[0]), .ready(rdy_w[0]),
    .sd(sd_w[0]), .sc(sc_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  frame_serializer #(.DATA_W(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
    .c(clk), .rst_n(rst_n), .din(din8[1]), .load(ld[1]), .ready(rdy_w[1]),
    .sd(sd_w[1]), .sc(sc_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  frame_serializer #(.DATA_W(8), .DIV(4), .PARITY_EN(0), .PARITY_ODD(0)) u2 (
    .c(clk), .rst_n(rst_n), .din(din8[2]), .load(ld[2]), .ready(rdy_w[2]),
    .sd(sd_w[2]), .sc(sc_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  frame_serializer #(.DATA_W(1), .DIV(2), .PARITY_EN(1), .PARITY_ODD(0)) u3 (
    .c(clk), .rst_n(rst_n), .din(din3), .load(ld[3]), .ready(rdy_w[3]),
    .sd(sd_w[3]), .sc(sc_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  // {sd, sc, busy, done, ready}
  function automatic logic [4:0] obs(input int inst);
    return {sd_w[inst], sc_w[inst], busy_w[inst], done_w[inst], rdy_w[inst]};
  endfunction

  task automatic check(input string name, input int inst, input int cyc,
                       input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", name, inst, cyc, got, exp);
    end
  endtask

  task automatic set_din(input int inst, input int word);
    if (inst < 3) din8[inst] = word[7:0];
    else din3 = word[0];
  endtask

  // Called just after a negedge with load already set up; the next edge accepts.
  task automatic expect_frame(input int inst, input int word, input int dw, input int div,
                              input int pen, input int podd, input int drop_at,
                              input int new_din, output int busy_cnt, output int cap);
    int bits[$];
    int par, nb, f, ncap;
    logic [4:0] got, exp_v;
    logic prev_sd;
    bits.push_back(0);
    par = podd;
    for (int i = 0; i < dw; i++) begin
      bits.push_back((word >> i) & 1);
      par ^= (word >> i) & 1;
    end
    if (pen != 0) bits.push_back(par);
    bits.push_back(1);
    nb = bits.size();
    f = div * nb;
    busy_cnt = 0;
    cap = 0;
    ncap = 0;
    prev_sd = 1'b1;
    for (int cyc = 0; cyc <= f; cyc++) begin
      @(negedge clk);
      got = obs(inst);
      if (cyc < f)
        exp_v = {bits[cyc / div] != 0, (cyc % div) == (div / 2), 1'b1, 1'b0, 1'b0};
      else
        exp_v = 5'b10011;
      check("frame_outputs", inst, cyc, int'(got), int'(exp_v));
      if (got[2]) busy_cnt++;
      if (got[3]) begin
        check("sd_stable_at_sc", inst, cyc, int'(got[4]), int'(prev_sd));
        if (ncap < 31) cap |= int'(got[4]) << ncap;
        ncap++;
      end
      prev_sd = got[4];
      if (cyc == drop_at) ld[inst] = 1'b0;
      if (cyc == 1 && new_din >= 0) set_din(inst, new_din);
    end
    check("sc_pulse_count", inst, f, ncap, nb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, cp, w, gap;
    vecs[0] = '{0, 'hA5, 8, 4, 1, 0, 44, 1354};
    vecs[1] = '{1, 'h00, 8, 4, 1, 1, 44, 1536};
    vecs[2] = '{2, 'h00, 8, 4, 0, 0, 40, 512};
    vecs[3] = '{3, 'h01, 1, 2, 1, 0, 8, 14};
    vecs[4] = '{0, 'hFF, 8, 4, 1, 0, 44, 1534};
    vecs[5] = '{3, 'h00, 1, 2, 1, 0, 8, 8};
    vecs[6] = '{1, 'h81, 8, 4, 1, 1, 44, 1794};
    vecs[7] = '{2, 'h7E, 8, 4, 0, 0, 40, 764};

    rst_n = 1'b0;
    ld = '0;
    din8[0] = '0; din8[1] = '0; din8[2] = '0;
    din3 = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) check("reset_state", i, 0, int'(obs(i)), 'b10001);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) check("idle_state", i, 0, int'(obs(i)), 'b10001);

    // Table-driven frames with fixed expected length and latched bit pattern.
    for (int v = 0; v < 8; v++) begin
      set_din(vecs[v].inst, vecs[v].word);
      ld[vecs[v].inst] = 1'b1;
      expect_frame(vecs[v].inst, vecs[v].word, vecs[v].dw, vecs[v].div, vecs[v].pen,
                   vecs[v].podd, 0, -1, bc, cp);
      check("frame_len", vecs[v].inst, v, bc, vecs[v].exp_len);
      check("latched_bits", vecs[v].inst, v, cp, vecs[v].exp_cap);
      @(negedge clk);
      check("post_idle", vecs[v].inst, v, int'(obs(vecs[v].inst)), 'b10001);
    end

    // Load held high: back-to-back frames; mid-frame din change must not leak in.
    set_din(0, 'h3C);
    ld[0] = 1'b1;
    expect_frame(0, 'h3C, 8, 4, 1, 0, -1, 'hC3, bc, cp);
    expect_frame(0, 'hC3, 8, 4, 1, 0, 3, -1, bc, cp);
    check("b2b_second_len", 0, 0, bc, 44);

    // Asynchronous reset in the middle of a frame.
    set_din(0, 'hA5);
    ld[0] = 1'b1;
    @(negedge clk);
    ld[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("busy_before_abort", 0, 17, int'(busy_w[0]), 1);
    #1 rst_n = 1'b0;
    #1 check("async_reset", 0, 17, int'(obs(0)), 'b10001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("held_in_reset", 0, i, int'(obs(0)), 'b10001);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 0, i, int'(obs(0)), 'b10001);
    end
    ld[0] = 1'b1;
    expect_frame(0, 'hA5, 8, 4, 1, 0, 0, -1, bc, cp);
    check("recovered_bits", 0, 0, cp, 1354);

    // Random words with random idle gaps.
    for (int n = 0; n < 20; n++) begin
      w = int'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("gap_idle", 0, g, int'(obs(0)), 'b10001);
      end
      set_din(0, w);
      ld[0] = 1'b1;
      expect_frame(0, w, 8, 4, 1, 0, 0, -1, bc, cp);
      check("rand_len", 0, n, bc, 44);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
